// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU responder: operation codes, FSM states
// and the default operand width.
package alu_seq_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_XNOR = 4'd8,
    OP_NOT  = 4'd9,
    OP_SHR  = 4'd10,
    OP_SHL  = 4'd11,
    OP_ASHR = 4'd12,
    OP_RAND = 4'd13,
    OP_ROR  = 4'd14,
    OP_RXOR = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    RESP     = 2'd2
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first. The first
// step runs on the start edge, so done pulses right after the W-th step.
module alu_div_iter
  import alu_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_r, quo_r, dvs_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r, done_r;

  logic [W-1:0]  src_rem_s, src_quo_s, src_dvs_s, nrem_s, nquo_s;
  logic [W:0]    rem_sh_s;
  logic          fits_s;

  // One restoring step, fed from fresh operands on start or the running state.
  always_comb begin
    if (start) begin
      src_rem_s = {W{1'b0}};
      src_quo_s = dividend;
      src_dvs_s = divisor;
    end else begin
      src_rem_s = rem_r;
      src_quo_s = quo_r;
      src_dvs_s = dvs_r;
    end
    rem_sh_s = {src_rem_s, src_quo_s[W-1]};
    fits_s   = (rem_sh_s >= {1'b0, src_dvs_s});
    if (fits_s) begin
      nrem_s = W'(rem_sh_s - {1'b0, src_dvs_s});
    end else begin
      nrem_s = rem_sh_s[W-1:0];
    end
    nquo_s = {src_quo_s[W-2:0], fits_s};
  end

  // Iteration state, step counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r  <= {W{1'b0}};
      quo_r  <= {W{1'b0}};
      dvs_r  <= {W{1'b0}};
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        rem_r  <= nrem_s;
        quo_r  <= nquo_s;
        dvs_r  <= divisor;
        cnt_r  <= CW'(W - 1);
        busy_r <= 1'b1;
      end else if (busy_r) begin
        rem_r <= nrem_s;
        quo_r <= nquo_s;
        cnt_r <= cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/alu_seq_server.sv
// Valid/ready ALU responder: single-cycle operators answer on the accept edge,
// DIV/MOD with a nonzero divisor go through the iterative divider.
module alu_seq_server
  import alu_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [3:0]     req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic           rsp_err
);

  localparam int         DW    = 2 * W;
  localparam logic [W:0] W_LIM = (W + 1)'(W);

  state_e        state_r;
  op_e           op_r;
  logic          req_ready_r, rsp_valid_r, rsp_err_r;
  logic [DW-1:0] rsp_data_r;

  op_e           op_s;
  logic          accept_s, div_start_s, big_sh_s, err_s;
  logic [DW-1:0] res_s;
  logic [W-1:0]  shl_s, ashr_s;
  logic          div_busy_s, div_done_s;
  logic [W-1:0]  div_quo_s, div_rem_s;

  assign op_s        = op_e'(req_op);
  assign accept_s    = req_valid && req_ready_r;
  assign div_start_s = accept_s && is_div_op(op_s) && (req_b != {W{1'b0}});
  assign big_sh_s    = ({1'b0, req_b} >= W_LIM);

  alu_div_iter #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .dividend  (req_a),
    .divisor   (req_b),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Single-cycle operator mux; DIV/MOD rows here only ever serve divide-by-zero.
  always_comb begin
    res_s = {DW{1'b0}};
    err_s = 1'b0;
    if (big_sh_s) begin
      shl_s  = {W{1'b0}};
      ashr_s = {W{req_a[W-1]}};
    end else begin
      shl_s  = W'(req_a << req_b);
      ashr_s = W'($signed(req_a) >>> req_b);
    end
    case (op_s)
      OP_ADD:  res_s[W:0]    = {1'b0, req_a} + {1'b0, req_b};
      OP_SUB:  res_s[W-1:0]  = req_a - req_b;
      OP_MUL:  res_s         = {{W{1'b0}}, req_a} * {{W{1'b0}}, req_b};
      OP_DIV: begin
        res_s[W-1:0] = {W{1'b1}};
        err_s        = 1'b1;
      end
      OP_MOD: begin
        res_s[W-1:0] = req_a;
        err_s        = 1'b1;
      end
      OP_AND:  res_s[W-1:0]  = req_a & req_b;
      OP_OR:   res_s[W-1:0]  = req_a | req_b;
      OP_XOR:  res_s[W-1:0]  = req_a ^ req_b;
      OP_XNOR: res_s[W-1:0]  = ~(req_a ^ req_b);
      OP_NOT:  res_s[W-1:0]  = ~req_a;
      OP_SHR: begin
        if (big_sh_s) begin
          res_s[W-1:0] = {W{1'b0}};
        end else begin
          res_s[W-1:0] = req_a >> req_b;
        end
      end
      OP_SHL:  res_s[W-1:0]  = shl_s;
      OP_ASHR: res_s[W-1:0]  = ashr_s;
      OP_RAND: res_s[0]      = &req_b;
      OP_ROR:  res_s[0]      = |req_b;
      OP_RXOR: res_s[0]      = ^req_b;
      default: res_s         = {DW{1'b0}};
    endcase
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      op_r        <= OP_ADD;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r        <= op_s;
            req_ready_r <= 1'b0;
            if (div_start_s) begin
              state_r <= DIV_BUSY;
            end else begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= res_s;
              rsp_err_r   <= err_s;
            end
          end
        end
        DIV_BUSY: begin
          if (div_done_s) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= {{W{1'b0}}, (op_r == OP_MOD) ? div_rem_s : div_quo_s};
          end else if (!div_busy_s) begin
            // Divider lost its operation: recover rather than hang.
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_alu_seq_server.sv
// Self-checking bench for alu_seq_server (W=4): directed vectors with literal
// expectations plus a cycle-level reference model checked on every negedge.
module tb_alu_seq_server;
  import alu_seq_pkg::*;

  localparam int W  = 4;
  localparam int DW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [3:0]    req_op = 4'd0;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic          req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_data;

  int nchecks = 0;
  int nerrs   = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  alu_seq_server #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference result from the operator definitions: returns {err, data}.
  function automatic logic [DW:0] ref_op(input int op, input int a, input int b);
    int mask;
    int r;
    int sa;
    bit e;
    logic [DW:0] out;
    mask = (1 << W) - 1;
    r = 0;
    e = 1'b0;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    case (op)
      0:  r = a + b;
      1:  r = (a - b) & mask;
      2:  r = a * b;
      3:  begin if (b == 0) begin r = mask; e = 1'b1; end else r = a / b; end
      4:  begin if (b == 0) begin r = a;    e = 1'b1; end else r = a % b; end
      5:  r = a & b;
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = ~(a ^ b) & mask;
      9:  r = ~a & mask;
      10: r = (b >= W) ? 0 : (a >> b);
      11: r = (b >= W) ? 0 : ((a << b) & mask);
      12: r = (b >= W) ? ((sa < 0) ? mask : 0) : ((sa >>> b) & mask);
      13: r = (b == mask) ? 1 : 0;
      14: r = (b != 0) ? 1 : 0;
      15: r = $countones(b) % 2;
      default: r = 0;
    endcase
    out = {e, r[DW-1:0]};
    return out;
  endfunction

  // Transaction-level model: pending response, countdown, handshake.
  logic          m_ready = 1'b1;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_err = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic          p_err = 1'b0;
  int            m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
      m_left  <= 0;
    end else if (m_valid) begin
      if (rsp_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_data  <= p_data;
        m_err   <= p_err;
      end
    end else if (m_ready && req_valid) begin
      m_ready <= 1'b0;
      if ((req_op == 4'd3 || req_op == 4'd4) && req_b != '0) begin
        {p_err, p_data} <= ref_op(int'(req_op), int'(req_a), int'(req_b));
        m_left <= W;
      end else begin
        {m_err, m_data} <= ref_op(int'(req_op), int'(req_a), int'(req_b));
        m_valid <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_req_ready", 32'(req_ready), 32'(m_ready));
      check("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        check("model_rsp_data", 32'(rsp_data), 32'(m_data));
        check("model_rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [DW-1:0] ed, input logic ee, input int elat,
                       input int stall, input bit lit);
    int lat;
    bit got;
    @(negedge clk);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1'b1;
      else if (lit) check("busy_req_ready", 32'(req_ready), 32'd0);
    end
    if (!got) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    if (lit) begin
      check("latency", 32'(lat), 32'(elat));
      check("rsp_data", 32'(rsp_data), 32'(ed));
      check("rsp_err", 32'(rsp_err), 32'(ee));
    end
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      req_op = 4'd0;
      req_a = 4'd1;
      req_b = 4'd1;
      @(negedge clk);
      if (lit) begin
        check("stall_data", 32'(rsp_data), 32'(ed));
        check("stall_req_ready", 32'(req_ready), 32'd0);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (lit) check("ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    do_op(4'd0,  4'd6,  4'd8, 8'h0E, 1'b0, 1, 0, 1'b1);  // ADD
    do_op(4'd1,  4'd2,  4'd3, 8'h0F, 1'b0, 1, 0, 1'b1);  // SUB
    do_op(4'd2,  4'd8,  4'd8, 8'h40, 1'b0, 1, 0, 1'b1);  // MUL
    do_op(4'd12, 4'h8,  4'd2, 8'h0E, 1'b0, 1, 0, 1'b1);  // ASHR
    do_op(4'd11, 4'd5,  4'd4, 8'h00, 1'b0, 1, 0, 1'b1);  // SHL b=W
    do_op(4'd3,  4'd8,  4'd2, 8'h04, 1'b0, 5, 0, 1'b1);  // DIV
    do_op(4'd4,  4'd5,  4'd7, 8'h05, 1'b0, 5, 0, 1'b1);  // remainder
    do_op(4'd3,  4'd5,  4'd0, 8'h0F, 1'b1, 1, 0, 1'b1);  // DIV by 0
    do_op(4'd4,  4'd5,  4'd0, 8'h05, 1'b1, 1, 0, 1'b1);  // remainder by 0
    do_op(4'd7,  4'd6,  4'd8, 8'h0E, 1'b0, 1, 3, 1'b1);  // XOR with backpressure
    do_op(4'd0,  4'hF,  4'hF, 8'h1E, 1'b0, 1, 0, 1'b1);  // ADD carry
    do_op(4'd2,  4'hF,  4'hF, 8'hE1, 1'b0, 1, 0, 1'b1);  // MUL full width
    do_op(4'd10, 4'hC,  4'd2, 8'h03, 1'b0, 1, 0, 1'b1);  // SHR
    do_op(4'd12, 4'h8,  4'd9, 8'h0F, 1'b0, 1, 0, 1'b1);  // ASHR b>=W
    do_op(4'd12, 4'h7,  4'd1, 8'h03, 1'b0, 1, 0, 1'b1);  // ASHR positive
    do_op(4'd13, 4'd0,  4'hF, 8'h01, 1'b0, 1, 0, 1'b1);  // RAND
    do_op(4'd14, 4'd3,  4'h0, 8'h00, 1'b0, 1, 0, 1'b1);  // ROR
    do_op(4'd15, 4'd0,  4'h7, 8'h01, 1'b0, 1, 0, 1'b1);  // RXOR
    do_op(4'd9,  4'd5,  4'd0, 8'h0A, 1'b0, 1, 0, 1'b1);  // NOT
    do_op(4'd8,  4'd6,  4'd8, 8'h01, 1'b0, 1, 0, 1'b1);  // XNOR
    do_op(4'd3,  4'hF,  4'd4, 8'h03, 1'b0, 5, 1, 1'b1);  // DIV
    do_op(4'd4,  4'hF,  4'd4, 8'h03, 1'b0, 5, 0, 1'b1);  // remainder
    do_op(4'd3,  4'hF,  4'd1, 8'h0F, 1'b0, 5, 0, 1'b1);  // DIV by 1

    // Reset during the second DIV_BUSY cycle drops the operation.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 4'd3;
    req_a = 4'd8;
    req_b = 4'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("div_busy_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_div_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_div_ready", 32'(req_ready), 32'd1);
    repeat (8) begin
      @(negedge clk);
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end

    // Model-checked sweep over random operations and stalls.
    for (int k = 0; k < 40; k++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            8'h00, 1'b0, 0, $urandom_range(0, 2), 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/alu_seq_server.md
Name: alu_seq_server

Overview:
- Request/response responder that serves the operator set used across the codebase's data-flow blocks: arithmetic, bitwise, reduction and shift.
- An initiator issues {op, a, b} over a valid/ready request channel.
- The block returns a 2W-bit result plus an error flag over a valid/ready response channel.
- Single-cycle ops answer in 1 cycle. DIV/MOD run on an iterative restoring divider.

Parameters:
- W, 4, operand width in bits (W >= 2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  4  operation code, see op_e
- req_a  in  W  operand a
- req_b  in  W  operand b
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_data  out  2W  result, zero-extended unless stated
- rsp_err  out  1  divide-by-zero flag

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, state=IDLE, divider cleared.
- Reset has priority over everything. Reset mid-DIV drops the operation; no response is issued.
- FSM states: IDLE, DIV_BUSY, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, operands and op are captured.
    - DIV/MOD with b!=0 -> DIV_BUSY.
    - All other ops, including divide-by-zero -> RESP, with result registered that edge.
  - DIV_BUSY: req_ready=0. Exactly W iterations, one quotient bit per cycle, MSB first. Then -> RESP.
  - RESP: rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready=1. On that handshake -> IDLE.
- req_ready is 0 in RESP and DIV_BUSY. There is no back-to-back accept in the response-handshake cycle.
- Latency from the accept edge to rsp_valid high:
  - 1 cycle for single-cycle ops and for divide-by-zero.
  - 1+W cycles for DIV/MOD.
- Op results (all arithmetic unsigned except ASHR):
  - ADD = a+b, W+1 bits, carry kept.
  - SUB = (a-b) mod 2^W.
  - MUL = a*b, full 2W bits.
  - DIV = floor(a/b). MOD = a%b.
  - AND, OR, XOR, XNOR bitwise on W bits. NOT = ~a.
  - SHR / SHL: a shifted by the full value of b. If b>=W, result is 0. SHL is truncated to W bits.
  - ASHR: a treated as signed, shifted right by b with sign fill. If b>=W, result is all sign bits.
  - RAND / ROR / RXOR: reduction of b into a 1-bit result in bit 0.
- Divide-by-zero:
  - DIV returns quotient all-ones (W bits); MOD returns a.
  - rsp_err=1; 1-cycle latency; divider not started.
- rsp_err is 0 for every other response.
- Undefined op codes return 0 with rsp_err=0.
- req_* inputs are ignored whenever req_ready=0.

Decomposition:
- Package alu_seq_pkg holds:
  - op_e, 4-bit: ADD=0, SUB=1, MUL=2, DIV=3, MOD=4, AND=5, OR=6, XOR=7, XNOR=8, NOT=9, SHR=10, SHL=11, ASHR=12, RAND=13, ROR=14, RXOR=15.
  - state_e.
  - Default W.
- Sub-module alu_div_iter: restoring divider.
  - Ports: clk, rst, start, dividend, divisor, busy, done, quotient, remainder.
  - done is a 1-cycle pulse after W cycles.
- Top level holds the FSM, the single-cycle operator mux and the response register.

Test Plan (W=4):
- ADD a=6, b=8 accepted at edge n -> rsp_valid at n+1, rsp_data=0x0E, rsp_err=0. SUB a=2, b=3 -> 0x0F.
- MUL a=8, b=8 -> rsp_data=0x40. ASHR a=4'b1000, b=2 -> 0x0E. SHL a=5, b=4 -> 0x00.
- DIV a=8, b=2 -> rsp_valid exactly 5 cycles after accept, rsp_data=4. MOD a=5, b=7 -> 5. req_ready=0 throughout.
- DIV a=5, b=0 -> rsp_valid after 1 cycle, rsp_data=0x0F, rsp_err=1. MOD a=5, b=0 -> rsp_data=5, rsp_err=1.
- Backpressure: XOR a=6, b=8, rsp_ready held low 3 cycles -> rsp_data=0x0E stable and req_ready=0. Raise rsp_ready -> req_ready=1 the next cycle.
- rst asserted on the 2nd DIV_BUSY cycle of DIV a=8, b=2 -> next cycle rsp_valid=0 and req_ready=1. No stale response appears afterwards.
